// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART packet receiver: packet FSM states,
// byte-receiver states, the default header byte and a helper that derives the
// baud divisor from clock frequency and baud rate.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_HOLD    = 2'd2
    } pkt_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'h02;

    // Rounded clk cycles per UART bit, e.g. (50_000_000, 115200) -> 434.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 byte deserialiser with 2-FF input synchroniser, mid-bit sampling,
// false-start rejection and stop-bit check.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   rx_in       raw serial line, idle high
//   data        last deserialised byte (stable while byte_valid is high)
//   byte_valid  one-cycle pulse, cycle after a stop bit sampled high
//   frame_err   one-cycle pulse, cycle after a stop bit sampled low
//   idle        receiver is waiting for a start bit
// -----------------------------------------------------------------------------
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       idle
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              rx_p0, rx_p1, rx_p2;
    rx_state_t         state, state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic              sample;
    logic              start_edge;

    // Stage p0/p1: metastability synchroniser. Stage p2: previous value for
    // edge detection. Reset to 0 so a line already low at reset release is
    // not mistaken for a start bit; a real high-to-low transition is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b0;
            rx_p1 <= 1'b0;
            rx_p2 <= 1'b0;
        end else begin
            rx_p0 <= rx_in;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign start_edge = rx_p2 & ~rx_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= R_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            R_IDLE:  if (start_edge) state_next = R_START;
            R_START: if (sample) state_next = rx_p1 ? R_IDLE : R_DATA;
            R_DATA:  if (sample && bit_cnt == 4'd7) state_next = R_STOP;
            R_STOP:  if (sample) state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    // The start sample comes half a bit after the edge; every later sample
    // is one full bit after the previous one.
    always_comb begin
        sample = 1'b0;
        idle   = 1'b0;
        case (state)
            R_IDLE:         idle   = 1'b1;
            R_START:        sample = (baud_cnt == HALF_LAST);
            R_DATA, R_STOP: sample = (baud_cnt == FULL_LAST);
            default:        sample = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (state == R_IDLE || sample) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;

            if (state != R_DATA) bit_cnt <= '0;
            else if (sample)     bit_cnt <= bit_cnt + 1'b1;

            // LSB arrives first, so shift in from the top.
            if (state == R_DATA && sample) shift <= {rx_p1, shift[7:1]};

            byte_valid <= (state == R_STOP) && sample && rx_p1;
            frame_err  <= (state == R_STOP) && sample && !rx_p1;
        end
    end

    assign data = shift;

endmodule

// File: rtl/uart_packet_rx.sv
// -----------------------------------------------------------------------------
// uart_packet_rx
// Packet receiver: a HEADER byte followed by PAYLOAD_BYTES payload bytes is
// assembled into one wide word offered on a valid/ready handshake.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rx_in        raw serial line, idle high
//   pkt_data     payload, byte k at [8k+7:8k]
//   pkt_valid    pkt_data holds a complete packet
//   pkt_ready    consumer accepts pkt_data
//   busy         header accepted, packet not yet handed off or aborted
//   frame_err    pulse: stop bit sampled low
//   hdr_err      pulse: first byte differs from HEADER
//   timeout_err  pulse: inter-byte gap exceeded TIMEOUT_BITS bit times
//   overrun_err  pulse: byte dropped while a packet is being held
// -----------------------------------------------------------------------------
module uart_packet_rx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT  = 434,
    parameter int         PAYLOAD_BYTES = 8,
    parameter logic [7:0] HEADER        = DEFAULT_HEADER,
    parameter int         TIMEOUT_BITS  = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_in,
    output logic [8*PAYLOAD_BYTES-1:0] pkt_data,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       hdr_err,
    output logic                       timeout_err,
    output logic                       overrun_err
);

    localparam int CNT_W     = $clog2(PAYLOAD_BYTES + 1);
    localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_frame_err;
    logic             rx_idle;
    pkt_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_hit;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_frame_err),
        .idle       (rx_idle)
    );

    // The cycle that completes the GAP_LIMIT-th idle cycle since the last
    // accepted byte is the timeout cycle.
    assign gap_hit = (state == S_PAYLOAD) && rx_idle && !rx_valid && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HDR:
                if (rx_valid && rx_data == HEADER) state_next = S_PAYLOAD;
            S_PAYLOAD:
                if (rx_frame_err)                      state_next = S_HDR;
                else if (rx_valid && cnt == CNT_LAST)  state_next = S_HOLD;
                else if (gap_hit)                      state_next = S_HDR;
            S_HOLD:
                // pkt_valid is high throughout S_HOLD, so ready alone completes it.
                if (pkt_ready) state_next = S_HDR;
            default:
                state_next = S_HDR;
        endcase
    end

    always_comb begin
        pkt_valid   = (state == S_HOLD);
        busy        = (state != S_HDR);
        hdr_err     = (state == S_HDR) && rx_valid && (rx_data != HEADER);
        timeout_err = gap_hit;
        overrun_err = (state == S_HOLD) && rx_valid;
        frame_err   = rx_frame_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            gap_cnt  <= '0;
            pkt_data <= '0;
        end else begin
            if (state == S_HDR) begin
                cnt <= '0;
            end else if (state == S_PAYLOAD && rx_valid) begin
                cnt <= cnt + 1'b1;
                for (int k = 0; k < PAYLOAD_BYTES; k++) begin
                    if (cnt == CNT_W'(k)) pkt_data[8*k +: 8] <= rx_data;
                end
            end

            // Gap is held, not cleared, while a byte is in flight.
            if (state != S_PAYLOAD || rx_valid) gap_cnt <= '0;
            else if (rx_idle)                   gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_packet_rx
// Directed bench for uart_packet_rx (CLKS_PER_BIT=16, PAYLOAD_BYTES=8).
// A packet-level model predicts every output on every cycle from the bytes
// the driver sends; directed literal checks pin the model's timing and data.
// -----------------------------------------------------------------------------
module tb_uart_packet_rx;

    localparam int         CPB  = 16;
    localparam int         NPB  = 8;
    localparam int         TOB  = 20;
    localparam logic [7:0] HDR  = 8'h02;
    // From the first clock edge that sees the start bit to the cycle that
    // shows byte_valid: 2 cycles of synchroniser/edge detection, half a bit
    // to the start-bit centre, then 9 further bits to the stop-bit centre.
    localparam int BYTE_LAT    = 2 + CPB / 2 + 9 * CPB;
    localparam int TIMEOUT_CYC = TOB * CPB;

    logic            clk;
    logic            rst;
    logic            rx_in;
    logic [8*NPB-1:0] pkt_data;
    logic            pkt_valid;
    logic            pkt_ready;
    logic            busy;
    logic            frame_err;
    logic            hdr_err;
    logic            timeout_err;
    logic            overrun_err;
    logic [5:0]      flags;

    uart_packet_rx #(
        .CLKS_PER_BIT  (CPB),
        .PAYLOAD_BYTES (NPB),
        .HEADER        (HDR),
        .TIMEOUT_BITS  (TOB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .hdr_err     (hdr_err),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    assign flags = {pkt_valid, busy, frame_err, hdr_err, timeout_err, overrun_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       ok;
    } ev_t;

    ev_t evq[$];
    int  n_pass  = 0;
    int  n_total = 0;
    int  last_ev = 0;

    // Observation statistics, cleared by the stimulus between scenarios.
    int          n_fe, n_he, n_to, n_ov, n_vrise, n_vcyc;
    int          vrise_cyc, to_cyc;
    logic [63:0] vdata;
    logic        prev_v = 1'b0;

    // Model state: mode 0 = waiting for header, 1 = collecting, 2 = holding.
    int          m_mode = 0;
    int          m_cnt  = 0;
    int          m_last = 0;
    logic [63:0] m_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clear_stats();
        n_fe = 0; n_he = 0; n_to = 0; n_ov = 0; n_vrise = 0; n_vcyc = 0;
        vrise_cyc = -1; to_cyc = -1; vdata = '0;
    endtask

    always @(negedge clk) begin
        ev_t        ev;
        logic       bv, fe, e_to;
        logic [7:0] bd;
        logic [5:0] e_flags;
        if (rst) begin
            m_mode = 0;
            m_cnt  = 0;
            m_data = '0;
            evq.delete();
            check("reset_flags", 64'(flags), 64'd0);
            check("reset_data", pkt_data, 64'd0);
        end else begin
            bv = 1'b0; fe = 1'b0; bd = 8'h00;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                bv = ev.ok;
                fe = !ev.ok;
                bd = ev.d;
            end
            // Stimulus keeps the line idle whenever a gap grows this long.
            e_to = (m_mode == 1) && !bv && ((cyc - m_last) == TIMEOUT_CYC);
            e_flags = {m_mode == 2, m_mode != 0, fe,
                       (m_mode == 0) && bv && (bd != HDR), e_to, (m_mode == 2) && bv};
            check("flags", 64'(flags), 64'(e_flags));
            check("pkt_data", pkt_data, m_data);

            if (pkt_valid) begin
                n_vcyc++;
                if (!prev_v) begin
                    n_vrise++;
                    vrise_cyc = cyc;
                    vdata = pkt_data;
                end
            end
            if (frame_err)   n_fe++;
            if (hdr_err)     n_he++;
            if (overrun_err) n_ov++;
            if (timeout_err) begin
                n_to++;
                to_cyc = cyc;
            end

            case (m_mode)
                0: if (bv && bd == HDR) begin
                    m_mode = 1;
                    m_cnt  = 0;
                    m_last = cyc;
                end
                1: if (fe || e_to) begin
                    m_mode = 0;
                end else if (bv) begin
                    m_data[8*m_cnt +: 8] = bd;
                    m_cnt++;
                    m_last = cyc;
                    if (m_cnt == NPB) m_mode = 2;
                end
                default: if (pkt_ready) m_mode = 0;
            endcase
        end
        prev_v = pkt_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge; the start bit is seen at the next edge.
    task automatic send_byte(input logic [7:0] d, input logic stop_ok);
        ev_t        e;
        logic [9:0] frame;
        frame = {stop_ok, d, 1'b0};
        e.cyc = cyc + 1 + BYTE_LAT;
        e.d   = d;
        e.ok  = stop_ok;
        evq.push_back(e);
        last_ev = e.cyc;
        for (int i = 0; i < 10; i++) begin
            rx_in = frame[i];
            repeat (CPB) tick();
        end
        rx_in = 1'b1;
    endtask

    task automatic send_packet(input logic [7:0] h, input logic [63:0] payload);
        send_byte(h, 1'b1);
        for (int i = 0; i < NPB; i++) send_byte(payload[8*i +: 8], 1'b1);
    endtask

    initial begin
        logic [7:0] part;
        rx_in = 1'b1;
        pkt_ready = 1'b1;
        rst = 1'b1;
        clear_stats();
        repeat (3) tick();
        check("init_flags", 64'(flags), 64'd0);
        check("init_data", pkt_data, 64'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Basic packet with consumer always ready.
        clear_stats();
        send_packet(HDR, 64'h8877665544332211);
        repeat (10) tick();
        check("t1_vrise", 64'(n_vrise), 64'd1);
        check("t1_vcycles", 64'(n_vcyc), 64'd1);
        check("t1_latency", 64'(vrise_cyc - last_ev), 64'd1);
        check("t1_data", vdata, 64'h8877665544332211);
        check("t1_errs", 64'(n_fe + n_he + n_to + n_ov), 64'd0);

        // Bad header, then a good packet.
        clear_stats();
        send_byte(8'hA5, 1'b1);
        send_packet(HDR, 64'h7E81FF0055AA0FF0);
        repeat (10) tick();
        check("t2_hdr_err", 64'(n_he), 64'd1);
        check("t2_data", vdata, 64'h7E81FF0055AA0FF0);

        // Inter-byte timeout after three payload bytes.
        clear_stats();
        send_byte(HDR, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        repeat (TIMEOUT_CYC + 10) tick();
        check("t3_to_count", 64'(n_to), 64'd1);
        check("t3_to_cycle", 64'(to_cyc - last_ev), 64'd320);
        check("t3_no_valid", 64'(n_vrise), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);

        // Framing error aborts the packet.
        clear_stats();
        send_byte(HDR, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (20) tick();
        check("t4_frame_err", 64'(n_fe), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);

        // Short low glitch on an idle line: a false start.
        clear_stats();
        rx_in = 1'b0;
        repeat (4) tick();
        rx_in = 1'b1;
        repeat (40) tick();
        check("t4_glitch_events", 64'(n_fe + n_he + n_to + n_ov + n_vrise), 64'd0);
        check("t4_glitch_busy", 64'(busy), 64'd0);

        // Held packet, overrun byte, then handshake.
        clear_stats();
        pkt_ready = 1'b0;
        send_packet(HDR, 64'h0123456789ABCDEF);
        repeat (5) tick();
        check("t5_held_valid", 64'(pkt_valid), 64'd1);
        send_byte(HDR, 1'b1);
        repeat (5) tick();
        check("t5_overrun", 64'(n_ov), 64'd1);
        check("t5_data_kept", pkt_data, 64'h0123456789ABCDEF);
        pkt_ready = 1'b1;
        tick();
        check("t5_valid_fall", 64'(pkt_valid), 64'd0);
        check("t5_busy_fall", 64'(busy), 64'd0);
        repeat (5) tick();
        check("t5_one_xfer", 64'(n_vrise), 64'd1);

        // Reset during data bit 4 of payload byte index 3.
        clear_stats();
        send_byte(HDR, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        part = 8'h44;
        rx_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx_in = part[i];
            repeat (CPB) tick();
        end
        rx_in = part[4];
        repeat (CPB / 2) tick();
        rst = 1'b1;
        #1;
        check("t6_rst_flags", 64'(flags), 64'd0);
        check("t6_rst_data", pkt_data, 64'd0);
        rx_in = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        clear_stats();
        send_packet(HDR, 64'hCAFEF00D12345678);
        repeat (10) tick();
        check("t6_vrise", 64'(n_vrise), 64'd1);
        check("t6_data", vdata, 64'hCAFEF00D12345678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
Parametrised RS-232 packet receiver feeding the AES datapath. Deserialises 8N1 UART bytes and validates a header byte. Collects PAYLOAD_BYTES payload bytes into one wide word and presents that word on a valid/ready handshake. Adds mid-bit sampling, false-start rejection, framing, header, timeout and overrun error reporting.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
PAYLOAD_BYTES, 8, payload bytes per packet; must be >= 1.
HEADER, 8'h02, required first byte of every packet.
TIMEOUT_BITS, 20, maximum idle gap between payload bytes, in bit times.

Ports:
clk  in  1  system clock
rst  in  1  reset
rx_in  in  1  asynchronous serial line, idle high
pkt_data  out  8*PAYLOAD_BYTES  assembled payload; byte k at [8k+7:8k]
pkt_valid  out  1  pkt_data holds a complete packet
pkt_ready  in  1  consumer accepts pkt_data
busy  out  1  high from header accepted until packet handed off or aborted
frame_err  out  1  one-cycle pulse: stop bit sampled low
hdr_err  out  1  one-cycle pulse: first byte != HEADER
timeout_err  out  1  one-cycle pulse: inter-byte gap exceeded
overrun_err  out  1  one-cycle pulse: byte dropped while pkt_valid held

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, all outputs are 0, pkt_data is 0, FSM is in S_HDR and all counters are 0.
- rx_in passes through a 2-FF synchroniser. All sampling uses the synchronised signal.
- Byte receiver:
  - Idle until a high-to-low transition is seen.
  - Re-samples at CLKS_PER_BIT/2 (integer division). If the line is high there, this is a false start: return to idle with no output.
  - Samples data bits 0..7, LSB first, at successive full CLKS_PER_BIT intervals, then samples the stop bit.
  - Stop bit = 1: byte_valid pulses for one cycle on the cycle after the stop sample. Stop bit = 0: frame_err pulses instead and the byte is discarded.
  - After the stop sample the receiver returns to idle immediately, so back-to-back bytes are supported.
- Packet FSM:
  - S_HDR: on byte_valid with byte == HEADER, go to S_PAYLOAD with cnt = 0 and busy = 1. On any other byte, pulse hdr_err and stay in S_HDR.
  - S_PAYLOAD: each byte_valid writes pkt_data[8*cnt +: 8], increments cnt and clears the gap counter. When the byte with cnt == PAYLOAD_BYTES-1 is written, go to S_HOLD; pkt_valid rises on the next cycle.
  - S_PAYLOAD gap counter: counts clk cycles while the byte receiver is idle. Reaching TIMEOUT_BITS*CLKS_PER_BIT pulses timeout_err and returns to S_HDR with busy = 0.
  - S_PAYLOAD framing error: frame_err also aborts to S_HDR.
  - Abort semantics: on any abort, the partial pkt_data is left as-is, and pkt_valid never rises for that packet.
  - S_HOLD: pkt_valid = 1 and pkt_data is held stable. On the cycle with pkt_valid & pkt_ready, the transfer completes; on the next cycle pkt_valid = 0, busy = 0 and the state is S_HDR.
  - S_HOLD incoming bytes: the byte receiver keeps running. Any byte_valid in S_HOLD pulses overrun_err and the byte is dropped, including a HEADER byte.
  - Simultaneous events: if byte_valid and the handshake occur in the same cycle, the byte is dropped with overrun_err.
- Width rules:
  - cnt is $clog2(PAYLOAD_BYTES+1) bits wide.
  - Bit counter is 4 bits wide.
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide.
  - Gap counter is $clog2(TIMEOUT_BITS*CLKS_PER_BIT+1) bits wide.
- Latency: pkt_valid rises exactly 2 cycles after the stop-bit sample of the last payload byte.
- Reset mid-frame: the in-flight byte and packet are discarded immediately. After reset release, only a fresh start bit is recognised.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef (S_HDR, S_PAYLOAD, S_HOLD).
  - Default HEADER constant.
  - Function computing CLKS_PER_BIT from clock frequency and baud rate.
- Sub-module uart_byte_rx: synchroniser, baud counter, false-start and framing checks. Outputs byte, byte_valid and frame_err.
- Top level: packet FSM, payload register, gap counter, error pulses.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and PAYLOAD_BYTES=8.
- Send 02 11 22 33 44 55 66 77 88 with pkt_ready=1 -> pkt_data=64'h8877665544332211; pkt_valid high exactly 1 cycle, 2 cycles after the last stop sample; no error pulses.
- Send A5 then a full valid packet -> hdr_err pulses once; the packet is then received correctly.
- Send 02 then 3 bytes, then idle 20*16 cycles -> timeout_err pulses at cycle 320 of the gap; busy falls; pkt_valid never rises.
- Send 02 then 1 byte with stop bit = 0 -> frame_err pulses and FSM returns to S_HDR. Separately, a 4-cycle low glitch on idle rx_in -> no output and no error.
- Complete a packet with pkt_ready=0, then send byte 02 -> overrun_err pulses; pkt_data unchanged. Then raise pkt_ready -> one transfer; pkt_valid falls on the next cycle.
- Assert rst during data bit 4 of payload byte 3 -> all outputs 0 at once. After reset release, a fresh packet is received correctly.
